rf_writeback_ctrl: RTL and testbench

Write-side controller for the 32×32 integer register file. It merges results from the single-cycle ALU and the long-latency load/mul-div path into the register file's single write port. It buffers long-latency results in a small FIFO and tracks pending destination registers in a scoreboard. It sits between the execute/memory stages and the register file's `regwrite`/`waddr`/`wdata` inputs.

---
 rtl/rf_writeback_ctrl.sv | 175 +++++++++++++++++
 tb/tb_rf_writeback_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_ctrl.sv
// rf_writeback_ctrl: merges single-cycle ALU results and long-latency results
// (buffered in a small FIFO) into the register file's single write port, and
// keeps a scoreboard of destination registers with writes still pending.
// Optional feature macro: RF_WB_BYPASS_EN adds a read-side bypass of the
// registered write port (byp_raddr / byp_hit / byp_data).
module rf_writeback_ctrl #(
    parameter int XLEN         = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [4:0]                    alu_rd,
    input  logic [XLEN-1:0]               alu_data,
    input  logic                          lsu_valid,
    output logic                          lsu_ready,
    input  logic [4:0]                    lsu_rd,
    input  logic [XLEN-1:0]               lsu_data,
    input  logic                          issue_valid,
    input  logic [4:0]                    issue_rd,
    output logic [31:0]                   busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
`ifdef RF_WB_BYPASS_EN
    input  logic [4:0]                    byp_raddr,
    output logic                          byp_hit,
    output logic [XLEN-1:0]               byp_data,
`endif
    output logic                          rf_regwrite,
    output logic [4:0]                    rf_waddr,
    output logic [XLEN-1:0]               rf_wdata
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {NORMAL = 1'b0, DRAIN = 1'b1} state_t;

    state_t          state, state_nxt;
    logic [4:0]      q_rd   [FIFO_DEPTH];
    logic [XLEN-1:0] q_data [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   starve_cnt;
    logic [31:0]     busy_nxt;
    logic            fifo_empty, push, pop, starve_hit;
    logic            sel_valid;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    assign fifo_empty = (fifo_count == '0);
    // Ready depends only on occupancy, so a full FIFO refuses a push even in a popping cycle.
    assign lsu_ready  = (fifo_count != (AW+1)'(FIFO_DEPTH));
    assign push       = lsu_valid && lsu_ready;

    // A non-empty FIFO that has been passed over STARVE_LIMIT cycles in a row forces a drain.
    assign starve_hit = (state == NORMAL) && !fifo_empty && !pop &&
                        (starve_cnt == CW'(STARVE_LIMIT - 1));

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= NORMAL;
        else         state <= state_nxt;
    end

    // Next-state: DRAIN lasts a single cycle
    always_comb begin
        state_nxt = NORMAL;
        if (state == NORMAL && starve_hit) state_nxt = DRAIN;
    end

    // Output/select: ALU has priority in NORMAL, FIFO head wins in DRAIN
    always_comb begin
        alu_ready = 1'b0;
        pop       = 1'b0;
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        case (state)
            NORMAL: begin
                alu_ready = 1'b1;
                if (alu_valid) begin
                    sel_valid = 1'b1;
                    sel_rd    = alu_rd;
                    sel_data  = alu_data;
                end else if (!fifo_empty) begin
                    pop       = 1'b1;
                    sel_valid = 1'b1;
                    sel_rd    = q_rd[rd_ptr];
                    sel_data  = q_data[rd_ptr];
                end
            end
            DRAIN: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    sel_valid = 1'b1;
                    sel_rd    = q_rd[rd_ptr];
                    sel_data  = q_data[rd_ptr];
                end
            end
            default: ;
        endcase
    end

    // Starvation counter: counts consecutive NORMAL cycles with a waiting, unpopped head
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            starve_cnt <= '0;
        else if (state != NORMAL || fifo_empty || pop || starve_hit)
            starve_cnt <= '0;
        else
            starve_cnt <= starve_cnt + 1'b1;
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= lsu_rd;
            q_data[wr_ptr] <= lsu_data;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Scoreboard update: FIFO write clears, issue sets (set wins), x0 never pending
    always_comb begin
        busy_nxt = busy;
        if (pop)         busy_nxt[sel_rd]   = 1'b0;
        if (issue_valid) busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) busy <= '0;
        else         busy <= busy_nxt;
    end

    // Registered write port; an x0 result is consumed without a write strobe
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rf_regwrite <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
        end else begin
            rf_regwrite <= sel_valid && (sel_rd != '0);
            if (sel_valid && (sel_rd != '0)) begin
                rf_waddr <= sel_rd;
                rf_wdata <= sel_data;
            end
        end
    end

`ifdef RF_WB_BYPASS_EN
    // Forward the write that is about to commit to a same-cycle reader
    assign byp_hit  = rf_regwrite && (rf_waddr == byp_raddr) && (byp_raddr != '0);
    assign byp_data = byp_hit ? rf_wdata : '0;
`endif

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Self-checking bench for rf_writeback_ctrl: directed steps followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_rf_writeback_ctrl;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 4;
    localparam int STARVE = 8;

    logic            clk = 1'b0;
    logic            resetn;
    logic            alu_valid, alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid, lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [31:0]     busy;
    logic [2:0]      fifo_count;
    logic            rf_regwrite;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
`ifdef RF_WB_BYPASS_EN
    logic [4:0]      byp_raddr;
    logic            byp_hit;
    logic [XLEN-1:0] byp_data;
`endif

    rf_writeback_ctrl #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .resetn(resetn),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .busy(busy), .fifo_count(fifo_count),
`ifdef RF_WB_BYPASS_EN
        .byp_raddr(byp_raddr), .byp_hit(byp_hit), .byp_data(byp_data),
`endif
        .rf_regwrite(rf_regwrite), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: pending results as a queue, a drain flag, a run length
    // of passed-over cycles, a pending-register array and the expected write.
    typedef struct packed { logic [4:0] rd; logic [XLEN-1:0] data; } ent_t;
    ent_t        mq[$];
    bit          m_drain;
    int          m_blk;
    logic [31:0] m_busy;
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_alu_acc;
    bit          saw_drain;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_drain = 0; m_blk = 0; m_busy = '0; m_we = 0; m_alu_acc = 0;
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
        issue_valid = 0; issue_rd = '0;
    endtask

    // One clock: check state-derived outputs, advance the model, check the write port.
    task automatic cycle();
        int   sz;
        bit   pop, push, nxt_drain;
        ent_t e;
        #1;
        sz = mq.size();
        chk("alu_ready",  alu_ready,  !m_drain);
        chk("lsu_ready",  lsu_ready,  sz < DEPTH);
        chk("fifo_count", fifo_count, sz);
        chk("busy",       busy,       m_busy);
        if (!alu_ready) saw_drain = 1;
        push      = lsu_valid && (sz < DEPTH);
        m_alu_acc = !m_drain && alu_valid;
        pop       = (sz > 0) && (m_drain || !alu_valid);
        m_we = 0;
        if (m_alu_acc) begin
            if (alu_rd != 0) begin m_we = 1; m_waddr = alu_rd; m_wdata = alu_data; end
        end else if (pop) begin
            e = mq.pop_front();
            if (e.rd != 0) begin m_we = 1; m_waddr = e.rd; m_wdata = e.data; m_busy[e.rd] = 1'b0; end
        end
        if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        if (push) begin e.rd = lsu_rd; e.data = lsu_data; mq.push_back(e); end
        nxt_drain = 0;
        if (m_drain || pop || sz == 0) m_blk = 0;
        else begin
            m_blk++;
            if (m_blk == STARVE) begin nxt_drain = 1; m_blk = 0; end
        end
        @(posedge clk);
        #1;
        m_drain = nxt_drain;
        chk("rf_regwrite", rf_regwrite, m_we);
        if (m_we) begin
            chk("rf_waddr", rf_waddr, m_waddr);
            chk("rf_wdata", rf_wdata, m_wdata);
        end
`ifdef RF_WB_BYPASS_EN
        byp_raddr = m_we ? m_waddr : 5'd1;
        #1;
        chk("byp_hit",  byp_hit,  m_we && m_waddr != 0);
        chk("byp_data", byp_data, (m_we && m_waddr != 0) ? m_wdata : 32'h0);
`endif
    endtask

    initial begin
        idle();
`ifdef RF_WB_BYPASS_EN
        byp_raddr = '0;
`endif
        saw_drain = 0;
        model_reset();

        // Reset held while a push of rd=5 and an issue are presented
        resetn = 0;
        lsu_valid = 1; lsu_rd = 5'd5; lsu_data = 32'h77; issue_valid = 1; issue_rd = 5'd5;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_busy",       busy,       0);
        chk("rst_regwrite",   rf_regwrite, 0);
        chk("rst_alu_ready",  alu_ready,  1);
        idle();
        #3 resetn = 1;
        @(posedge clk); #1;

        // Basic ALU write, then an idle cycle to see the strobe drop
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
        cycle();
        chk("alu_wr_addr", rf_waddr, 3);
        chk("alu_wr_data", rf_wdata, 32'hDEADBEEF);
        idle(); cycle();
        chk("alu_wr_oneshot", rf_regwrite, 0);

        // x0: ALU write dropped, issue to x0 leaves busy[0] clear
        alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h1234;
        cycle();
        idle(); issue_valid = 1; issue_rd = 5'd0;
        cycle();
        idle(); cycle();
        chk("x0_busy0", busy[0], 0);

        // Scoreboard: issue x7, push result, pop with no ALU traffic
        issue_valid = 1; issue_rd = 5'd7; cycle();
        idle(); lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'h55; cycle();
        idle(); cycle();
        chk("sb_wr_addr", rf_waddr, 7);
        chk("sb_wr_data", rf_wdata, 32'h55);
        chk("sb_cleared", busy[7], 0);

        // Set and clear on the same bit in one cycle: set wins
        issue_valid = 1; issue_rd = 5'd7; cycle();
        idle(); lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'h66; cycle();
        idle(); issue_valid = 1; issue_rd = 5'd7; cycle();
        chk("sb_set_wins", busy[7], 1);
        idle(); cycle();

        // FIFO fill under continuous ALU traffic, then forced drain
        saw_drain = 0;
        alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h1000;
        for (int i = 0; i < 16; i++) begin
            lsu_valid = (i < 6); lsu_rd = 5'(10 + i); lsu_data = 32'hA000 + i;
            cycle();
            if (m_alu_acc) begin
                alu_rd = 5'(1 + (i % 8)); alu_data = 32'h1001 + i;
            end
        end
        chk("drain_seen", saw_drain, 1);
        idle();
        while (mq.size() > 0) cycle();

        // Mid-operation reset empties the FIFO and kills the write strobe
        alu_valid = 1; alu_rd = 5'd2; alu_data = 32'hBEEF;
        issue_valid = 1; issue_rd = 5'd9;
        lsu_valid = 1; lsu_rd = 5'd9; lsu_data = 32'h9;
        repeat (3) cycle();
        #2 resetn = 0;
        #1;
        chk("mid_rst_count",    fifo_count,  0);
        chk("mid_rst_busy",     busy,        0);
        chk("mid_rst_regwrite", rf_regwrite, 0);
        chk("mid_rst_alu_rdy",  alu_ready,   1);
        model_reset();
        idle();
        #2 resetn = 1;

        // Randomized traffic; the ALU result is held while not accepted
        m_alu_acc = 1;
        for (int i = 0; i < 400; i++) begin
            if (m_alu_acc || !alu_valid) begin
                alu_valid = ($urandom_range(0, 99) < 70);
                alu_rd    = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            lsu_valid   = ($urandom_range(0, 99) < 40);
            lsu_rd      = 5'($urandom_range(0, 7));
            lsu_data    = $urandom;
            issue_valid = ($urandom_range(0, 99) < 30);
            issue_rd    = 5'($urandom_range(0, 7));
            cycle();
        end
        idle();
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
